uart_rom_tx_seq: RTL and testbench

- Consumes the UART transmit message ROM: walks ROM addresses 0..MSG_LEN-1 and serialises each returned byte as 8N1 on a single TX line.
- Sits between the ROM (synchronous read, one-cycle latency) and the board TX pin.
- Started by a one-cycle pulse; reports busy and a completion pulse.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_baud_tick.sv | 35 +++
 rtl/uart_rom_tx_seq.sv | 171 +++++++++++++++++
 tb/tb_uart_rom_tx_seq.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encoding and constants for the ROM-driven UART transmitter
package uart_pkg;

  localparam int   UART_DATA_W     = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_e;

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - bit-period counter producing a one-cycle tick on its terminal count
module uart_baud_tick #(
  parameter int BAUD_DIV = 434
) (
  input  logic CLOCK,
  input  logic RESET_N,
  input  logic clear,
  output logic tick
);

  localparam int               CNT_W = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] TERM  = CNT_W'(BAUD_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Tick is decoded from the count so it marks the last cycle of each bit; clear wins over counting
  always_comb begin
    tick  = (cnt_q == TERM);
    cnt_d = cnt_q + CNT_W'(1);
    if (clear || tick) begin
      cnt_d = '0;
    end
  end

  // Counter register
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rom_tx_seq.sv
// rtl/uart_rom_tx_seq.sv - walks the message ROM and sends each byte as 8N1 (even parity with UART_TX_PARITY_EN)
module uart_rom_tx_seq
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = 434,
  parameter int MSG_LEN  = 10,
  parameter int ADDR_W   = 4
) (
  input  logic                   CLOCK,
  input  logic                   RESET_N,
  input  logic                   start,
  output logic [ADDR_W-1:0]      addr,
  input  logic [UART_DATA_W-1:0] rom_data,
  output logic                   tx,
  output logic                   busy,
  output logic                   done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MSG_LEN - 1);

  uart_state_e            state_q, state_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   tx_q, tx_d;
  logic [UART_DATA_W-1:0] shift_q, shift_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
`ifdef UART_TX_PARITY_EN
  logic                   parity_q, parity_d;
`endif
  logic                   tick;
  logic                   baud_clear;
  logic                   accept;
  logic                   last_bit;

  // A start coinciding with the done pulse is dropped so each message needs a fresh request
  assign accept   = (state_q == ST_IDLE) && start && !done_q;
  assign last_bit = (bit_cnt_q == 3'd7);

  uart_baud_tick #(
    .BAUD_DIV(BAUD_DIV)
  ) u_baud (
    .CLOCK  (CLOCK),
    .RESET_N(RESET_N),
    .clear  (baud_clear),
    .tick   (tick)
  );

  // State and datapath registers; tx resets straight to the idle level
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      tx_q      <= UART_IDLE_LEVEL;
      shift_q   <= '0;
      bit_cnt_q <= '0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      tx_q      <= tx_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  // Next-state selection; FETCH and LOAD are fixed single cycles around the ROM read latency
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = ST_FETCH;
      ST_FETCH:  state_d = ST_LOAD;
      ST_LOAD:   state_d = ST_START;
      ST_START:  if (tick) state_d = ST_DATA;
`ifdef UART_TX_PARITY_EN
      ST_DATA:   if (tick && last_bit) state_d = ST_PARITY;
      ST_PARITY: if (tick) state_d = ST_STOP;
`else
      ST_DATA:   if (tick && last_bit) state_d = ST_STOP;
`endif
      ST_STOP:   if (tick) state_d = (addr_q == LAST_ADDR) ? ST_IDLE : ST_FETCH;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Datapath updates; tx_d always carries the level for the next bit so tx stays a plain flop
  always_comb begin
    addr_d     = addr_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    tx_d       = tx_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    baud_clear = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif
    case (state_q)
      ST_IDLE: begin
        tx_d = UART_IDLE_LEVEL;
        if (accept) begin
          addr_d = '0;
          busy_d = 1'b1;
        end
      end
      ST_LOAD: begin
        shift_d    = rom_data;
        baud_clear = 1'b1;
        tx_d       = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d   = ^rom_data;
`endif
      end
      ST_START: begin
        if (tick) begin
          tx_d      = shift_q[0];
          bit_cnt_d = '0;
        end
      end
      ST_DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (last_bit) begin
`ifdef UART_TX_PARITY_EN
            tx_d = parity_q;
`else
            tx_d = UART_IDLE_LEVEL;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            tx_d      = shift_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (tick) tx_d = UART_IDLE_LEVEL;
      end
`endif
      ST_STOP: begin
        if (tick) begin
          if (addr_q == LAST_ADDR) begin
            done_d = 1'b1;
            busy_d = 1'b0;
            addr_d = '0;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
          end
        end
      end
      default: begin
        tx_d = tx_q;
      end
    endcase
  end

  assign addr = addr_q;
  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_uart_rom_tx_seq.sv
// tb/tb_uart_rom_tx_seq.sv - self-checking bench for uart_rom_tx_seq (honours UART_TX_PARITY_EN)
module tb_uart_rom_tx_seq;

  localparam int BAUD = 4;
  localparam int MSG  = 10;
  localparam int AW   = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NSLOT    = 11;
  localparam int PLAN_LAT = 460;
`else
  localparam int NSLOT    = 10;
  localparam int PLAN_LAT = 420;
`endif
  localparam int PER_BYTE = 2 + NSLOT * BAUD;
  localparam int TOTAL    = MSG * PER_BYTE;
  localparam int TAIL     = 8;

  typedef struct {
    logic [7:0] rom_byte;
    logic [9:0] exp_frame;
    logic       exp_par;
  } vec_t;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] addr;
  logic [7:0]    rom_data;
  logic          tx;
  logic          busy;
  logic          done;

  logic [7:0]    rom_mem [0:(1<<AW)-1];
  logic          tx_log  [1:TOTAL+TAIL];

  int checks;
  int failures;

  uart_rom_tx_seq #(
    .BAUD_DIV(BAUD),
    .MSG_LEN (MSG),
    .ADDR_W  (AW)
  ) dut (
    .CLOCK   (clk),
    .RESET_N (rst_n),
    .start   (start),
    .addr    (addr),
    .rom_data(rom_data),
    .tx      (tx),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom_mem[addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fill_rom(input logic [7:0] v);
    for (int i = 0; i < (1 << AW); i++) rom_mem[i] = v;
  endtask

  // Called just after a negedge: pulses start and checks every cycle against a slot-level model
  task automatic run_message(input string tag, input bit poke, output int lat);
    logic exp_tx [$];
    int   exp_addr [$];
    logic fb [0:NSLOT-1];
    int   n_tx, n_addr, n_busy, n_done, first_bad, done_cnt, done_cyc;
    n_tx = 0; n_addr = 0; n_busy = 0; n_done = 0;
    first_bad = -1; done_cnt = 0; done_cyc = -1;
    for (int b = 0; b < MSG; b++) begin
      fb[0] = 1'b0;
      for (int i = 0; i < 8; i++) fb[1+i] = rom_mem[b][i];
`ifdef UART_TX_PARITY_EN
      fb[9] = ^rom_mem[b];
`endif
      fb[NSLOT-1] = 1'b1;
      exp_tx.push_back(1'b1);
      exp_tx.push_back(1'b1);
      for (int s = 0; s < NSLOT; s++) repeat (BAUD) exp_tx.push_back(fb[s]);
      repeat (PER_BYTE) exp_addr.push_back(b);
    end
    repeat (TAIL) begin
      exp_tx.push_back(1'b1);
      exp_addr.push_back(0);
    end
    start = 1'b1;
    for (int c = 1; c <= TOTAL + TAIL; c++) begin
      @(negedge clk);
      start = 1'b0;
      tx_log[c] = tx;
      if (tx !== exp_tx[c-1]) begin
        n_tx++;
        if (first_bad < 0) first_bad = c;
      end
      if (addr !== AW'(exp_addr[c-1])) n_addr++;
      if (busy !== (c <= TOTAL)) n_busy++;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (done !== (c == TOTAL + 1)) n_done++;
      if (poke && (c == 50 || c == 200 || c == TOTAL + 1)) start = 1'b1;
    end
    lat = done_cyc - 1;
    chk($sformatf("%s tx_stream first_bad_cyc=%0d", tag, first_bad), n_tx, 0);
    chk({tag, " addr_seq"}, n_addr, 0);
    chk({tag, " busy_window"}, n_busy, 0);
    chk({tag, " done_timing"}, n_done, 0);
    chk({tag, " done_count"}, done_cnt, 1);
    chk({tag, " latency"}, lat, TOTAL);
  endtask

  vec_t vecs [6];
  int   lat;
  int   quiet_bad;
  logic [9:0] obs;

  initial begin
    vecs[0] = '{8'h0A, 10'b1000010100, 1'b0};
    vecs[1] = '{8'hFF, 10'b1111111110, 1'b0};
    vecs[2] = '{8'h00, 10'b1000000000, 1'b0};
    vecs[3] = '{8'h81, 10'b1100000010, 1'b0};
    vecs[4] = '{8'h5A, 10'b1010110100, 1'b0};
    vecs[5] = '{8'h01, 10'b1000000010, 1'b1};
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    start = 1'b0;
    fill_rom(8'h0A);

    repeat (3) @(negedge clk);
    chk("reset tx", tx, 1);
    chk("reset addr", addr, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_message("plan", 1'b0, lat);
    chk("plan_latency", lat, PLAN_LAT);

    for (int v = 0; v < 6; v++) begin
      fill_rom(vecs[v].rom_byte);
      run_message($sformatf("vec%0d", v), 1'b0, lat);
      for (int i = 0; i < 9; i++) obs[i] = tx_log[3 + i * BAUD + BAUD / 2];
      obs[9] = tx_log[3 + (NSLOT - 1) * BAUD + BAUD / 2];
      chk($sformatf("vec%0d frame_shape", v), obs, vecs[v].exp_frame);
`ifdef UART_TX_PARITY_EN
      chk($sformatf("vec%0d parity_bit", v), tx_log[3 + 9 * BAUD + BAUD / 2], vecs[v].exp_par);
`endif
    end

    fill_rom(8'h0A);
    run_message("start_while_busy", 1'b1, lat);

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < (1 << AW); i++) rom_mem[i] = 8'($urandom_range(0, 255));
      run_message($sformatf("random%0d", r), 1'b0, lat);
    end

    fill_rom(8'h0A);
    start = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("pre_reset tx", tx, 0);
    chk("pre_reset addr", addr, 2);
    #1 rst_n = 1'b0;
    #1;
    chk("async_reset tx", tx, 1);
    chk("async_reset busy", busy, 0);
    chk("async_reset addr", addr, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    quiet_bad = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0 || tx !== 1'b1) quiet_bad++;
    end
    chk("post_reset idle", quiet_bad, 0);
    run_message("after_reset", 1'b0, lat);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
